// File: rtl/fp_accum_sequencer.sv
// Reduces a stream of single-precision words to one sum through an external
// stb/ack adder. Build with NAN_SHORTCUT_EN to short-circuit runs containing a NaN.
module fp_accum_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             sum_valid,
  output logic [WIDTH-1:0] adder_a,
  output logic             adder_a_stb,
  input  logic             adder_a_ack,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_b_stb,
  input  logic             adder_b_ack,
  input  logic [WIDTH-1:0] adder_z,
  input  logic             adder_z_stb,
  output logic             adder_z_ack
);

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, SEND, WAIT_Z, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             a_done_q, a_done_d, b_done_q, b_done_d;
  logic             in_ready_q, in_ready_d, busy_q, busy_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic [WIDTH-1:0] adder_a_q, adder_a_d, adder_b_q, adder_b_d;
  logic             adder_a_stb_q, adder_a_stb_d, adder_b_stb_q, adder_b_stb_d;
  logic             adder_z_ack_q, adder_z_ack_d;
  logic             in_acc, a_xfer, b_xfer, z_xfer, issue;

`ifdef NAN_SHORTCUT_EN
  logic nan_q, nan_d;

  function automatic logic is_nan(input logic [WIDTH-1:0] w);
    return (w[30:23] == '1) && (w[22:0] != '0);
  endfunction
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    a_done_d      = a_done_q;
    b_done_d      = b_done_q;
    busy_d        = busy_q;
    sum_d         = sum_q;
    sum_valid_d   = 1'b0;
    adder_a_d     = adder_a_q;
    adder_b_d     = adder_b_q;
    adder_a_stb_d = adder_a_stb_q;
    adder_b_stb_d = adder_b_stb_q;
    adder_z_ack_d = adder_z_ack_q;
    in_acc        = in_valid && in_ready_q;
    a_xfer        = adder_a_stb_q && adder_a_ack;
    b_xfer        = adder_b_stb_q && adder_b_ack;
    z_xfer        = adder_z_stb && adder_z_ack_q;
    issue         = in_acc;
`ifdef NAN_SHORTCUT_EN
    nan_d         = nan_q;
    issue         = in_acc && !nan_q;
`endif

    if (a_xfer) adder_a_stb_d = 1'b0;
    if (b_xfer) adder_b_stb_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d  = 1'b1;
          cnt_d   = len;
          acc_d   = '0;
          state_d = (len == '0) ? DONE : LOAD;
`ifdef NAN_SHORTCUT_EN
          nan_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (in_acc) begin
          acc_d   = in_data;
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? DONE : FETCH;
`ifdef NAN_SHORTCUT_EN
          nan_d   = is_nan(in_data);
`endif
        end
      end
      FETCH: begin
        if (issue) begin
          adder_a_d     = acc_q;
          adder_b_d     = in_data;
          adder_a_stb_d = 1'b1;
          adder_b_stb_d = 1'b1;
          a_done_d      = 1'b0;
          b_done_d      = 1'b0;
          state_d       = SEND;
        end
`ifdef NAN_SHORTCUT_EN
        // The element that first raises the flag still goes out as an add;
        // only later elements are merely counted.
        if (in_acc) begin
          nan_d = nan_q | is_nan(in_data);
          if (nan_q) begin
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_d = DONE;
          end
        end
`endif
      end
      SEND: begin
        a_done_d = a_done_q | a_xfer;
        b_done_d = b_done_q | b_xfer;
        if (a_done_d && b_done_d) begin
          adder_z_ack_d = 1'b1;
          state_d       = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (z_xfer) begin
          acc_d         = adder_z;
          cnt_d         = cnt_q - LEN_W'(1);
          adder_z_ack_d = 1'b0;
          state_d       = (cnt_q == LEN_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        sum_d       = acc_q;
`ifdef NAN_SHORTCUT_EN
        if (nan_q) sum_d = WIDTH'(32'h7FC0_0000);
`endif
        sum_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD) || (state_d == FETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      sum_q         <= '0;
      sum_valid_q   <= 1'b0;
      adder_a_q     <= '0;
      adder_b_q     <= '0;
      adder_a_stb_q <= 1'b0;
      adder_b_stb_q <= 1'b0;
      adder_z_ack_q <= 1'b0;
`ifdef NAN_SHORTCUT_EN
      nan_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      sum_q         <= sum_d;
      sum_valid_q   <= sum_valid_d;
      adder_a_q     <= adder_a_d;
      adder_b_q     <= adder_b_d;
      adder_a_stb_q <= adder_a_stb_d;
      adder_b_stb_q <= adder_b_stb_d;
      adder_z_ack_q <= adder_z_ack_d;
`ifdef NAN_SHORTCUT_EN
      nan_q         <= nan_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign sum         = sum_q;
  assign sum_valid   = sum_valid_q;
  assign adder_a     = adder_a_q;
  assign adder_b     = adder_b_q;
  assign adder_a_stb = adder_a_stb_q;
  assign adder_b_stb = adder_b_stb_q;
  assign adder_z_ack = adder_z_ack_q;

endmodule
